// File: rtl/p_fetch.sv
// p_fetch: shared types for the instruction fetch unit
package p_fetch;
    typedef enum logic {FETCH, FLUSH} e_fetch_state;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } s_fetch_entry;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/m_fetch_fifo.sv
// m_fetch_fifo: small synchronous FIFO of fetch entries with flush and occupancy count
module m_fetch_fifo
    import p_fetch::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  s_fetch_entry               din,
    output s_fetch_entry               dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    s_fetch_entry mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_push = push && count != FULL;
    assign do_pop = pop && count != '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/m_fetch.sv
// m_fetch: credit-limited instruction fetch with in-order responses, tag queue and redirect flush
module m_fetch
    import p_fetch::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    e_fetch_state state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [CW-1:0] outstanding, out_nxt, fifo_count, tag_count;
    logic accept, resp_ok, resp_take, pop;
    logic [CW:0] credit_used;
    s_fetch_entry tag_head, instr_head;
    logic unused_tag;
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign unused_tag = ^{tag_head.instruction, tag_count};
    always_comb begin
        mem_req_valid = 1'b0;
        accept = 1'b0;
        resp_ok = 1'b0;
        resp_take = 1'b0;
        out_nxt = outstanding;
        pc_nxt = pc;
        state_nxt = state;
        // responses with nothing outstanding are protocol errors and are ignored
        resp_ok = mem_resp_valid && outstanding != '0;
        mem_req_valid = rst_n && state == FETCH && !redirect_valid && credit_used < (CW+1)'(DEPTH);
        accept = mem_req_valid && mem_req_ready;
        resp_take = resp_ok && state == FETCH && !redirect_valid;
        out_nxt = outstanding + CW'(accept) - CW'(resp_ok);
        pc_nxt = redirect_valid ? word_align(redirect_pc) : accept ? pc + 32'd4 : pc;
        state_nxt = redirect_valid ? (out_nxt != '0 ? FLUSH : FETCH) :
                    (state == FLUSH && out_nxt == '0) ? FETCH : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= word_align(RESET_PC);
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            outstanding <= out_nxt;
        end
    end
    assign pop = instr_valid && instr_ready && !redirect_valid;
    m_fetch_fifo #(.DEPTH(DEPTH)) u_tags (
        .clk  (clk),
        .rst_n(rst_n),
        .push (accept),
        .pop  (resp_take),
        .flush(redirect_valid),
        .din  ('{pc: pc, instruction: 32'h0}),
        .dout (tag_head),
        .count(tag_count)
    );
    m_fetch_fifo #(.DEPTH(DEPTH)) u_instr (
        .clk  (clk),
        .rst_n(rst_n),
        .push (resp_take),
        .pop  (pop),
        .flush(redirect_valid),
        .din  ('{pc: tag_head.pc, instruction: mem_resp_data}),
        .dout (instr_head),
        .count(fifo_count)
    );
    assign mem_req_addr = pc;
    assign instr_valid = fifo_count != '0;
    assign instruction = instr_head.instruction;
    assign instr_pc = instr_head.pc;
endmodule

// File: doc/m_fetch.md
M_FETCH -- requirements
Module: m_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be treated as 0.
REQ-002 Parameter DEPTH, default 2: instruction FIFO entries and maximum in-flight memory requests; legal range 2..8.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port mem_req_valid  output  1  fetch request valid.
REQ-006 Port mem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 Port mem_req_addr  output  32  word-aligned fetch address.
REQ-008 Port mem_resp_valid  input  1  in-order response valid; always accepted, no backpressure.
REQ-009 Port mem_resp_data  input  32  fetched instruction word.
REQ-010 Port redirect_valid  input  1  branch/exception redirect.
REQ-011 Port redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored.
REQ-012 Port instr_valid  output  1  instruction available to the decoder.
REQ-013 Port instr_ready  input  1  decoder consumes the instruction this cycle.
REQ-014 Port instruction  output  32  instruction word driven to the decoder's instruction input.
REQ-015 Port instr_pc  output  32  address of the instruction being presented.

Function
REQ-016 A request SHALL be accepted only when mem_req_valid and mem_req_ready are both high; mem_req_valid MAY drop without acceptance, and memory SHALL tolerate withdrawal.
REQ-017 FSM states: FETCH and FLUSH.
REQ-018 In FETCH: mem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH), using registered values only; a pop in the same cycle SHALL NOT free a credit.
REQ-019 On acceptance: pc += 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000); outstanding += 1; the accepted address SHALL be queued as the PC tag of that request.
REQ-020 Response in FETCH: push {tag, mem_resp_data} into the FIFO and decrement outstanding; credits guarantee the FIFO is never full at push.
REQ-021 Latency: a response accepted in cycle N SHALL appear on instr_valid/instruction/instr_pc in cycle N+1.
REQ-022 instr_valid = FIFO non-empty; outputs SHALL hold stable while instr_valid && !instr_ready.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-024 redirect_valid in any state: flush the FIFO, discard all tags, and set pc = {redirect_pc[31:2], 2'b00} at the next edge; the redirect wins over a same-cycle pop, push and acceptance.
REQ-025 After a redirect: go to FLUSH if outstanding (including any request accepted that cycle, minus any response consumed that cycle) is nonzero, else to FETCH.
REQ-026 In FLUSH: mem_req_valid = 0; each response SHALL be dropped and decrement outstanding; transition to FETCH on the edge where outstanding reaches 0.
REQ-027 A redirect during FLUSH SHALL overwrite pc and remain in FLUSH.
REQ-028 A response with outstanding = 0 is a protocol error; it SHALL be ignored, and the bench SHALL assert that it never occurs.

Reset
REQ-029 While rst_n = 0: state = FETCH, pc = RESET_PC, outstanding = 0, FIFO empty, mem_req_valid = 0, instr_valid = 0, instruction = 0, instr_pc = 0.
REQ-030 Reset mid-operation SHALL abandon in-flight requests; memory SHALL be reset by the same rst_n.
REQ-031 In the first cycle after deassertion, mem_req_valid = 1 and mem_req_addr = RESET_PC.

Structure
REQ-032 Package p_fetch SHALL hold e_fetch_state {FETCH, FLUSH} and s_fetch_entry {pc[31:0], instruction[31:0]}.
REQ-033 Sub-module m_fetch_fifo (parameterised DEPTH, s_fetch_entry payload, push/pop/flush, count) SHALL hold both instructions and the request-tag queue.
REQ-034 Counter widths SHALL be $clog2(DEPTH+1).

Verification
REQ-035 Reset release, memory always ready with 1-cycle response -> requests at 0x0, 0x4, 0x8...; instructions delivered in order with matching instr_pc.
REQ-036 instr_ready = 0 for 10 cycles -> exactly DEPTH requests issued, then mem_req_valid = 0; no entry lost or duplicated once instr_ready = 1.
REQ-037 Redirect to 0x1003 with 2 in flight -> FLUSH; both responses dropped; next request at 0x1000; first instr_pc delivered = 0x1000.
REQ-038 Redirect in the same cycle as a response, a pop and an acceptance -> FIFO empty next cycle; accepted request counted stale; no stale instruction is delivered.
REQ-039 pc = 0xFFFF_FFFC accepted -> next request at 0x0000_0000.
REQ-040 rst_n asserted with 2 in flight and the FIFO full -> all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC.
